// File: rtl/afc_cntr_seq_if.sv
// rtl/afc_cntr_seq_if.sv - AFC measurement request/result and analog counter signal bundle
interface afc_cntr_seq_if #(
  parameter int CNT_W = 14
);
  logic             meas_req;
  logic             meas_abort;
  logic [1:0]       rg_afc_vcostable_time;
  logic [6:0]       rg_afc_cnt_time;
  logic [CNT_W-1:0] ndec;
  logic [CNT_W-1:0] a2d_afc_ncntr;
  logic             afc_cntr_rstn;
  logic             afc_cntr_en;
  logic             afc_cntr_datasyn;
  logic             meas_busy;
  logic             meas_done;
  logic [CNT_W-1:0] meas_err;
  logic             meas_hi;

  // Calibration FSM and analog counter side: requests, timing config, counter result
  modport master (
    output meas_req, meas_abort, rg_afc_vcostable_time, rg_afc_cnt_time, ndec, a2d_afc_ncntr,
    input  afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn, meas_busy, meas_done, meas_err, meas_hi
  );

  // Sequencer side: owns counter timing and reports the frequency error
  modport slave (
    input  meas_req, meas_abort, rg_afc_vcostable_time, rg_afc_cnt_time, ndec, a2d_afc_ncntr,
    output afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn, meas_busy, meas_done, meas_err, meas_hi
  );
endinterface

// File: rtl/afc_cntr_seq.sv
// rtl/afc_cntr_seq.sv - AFC counter measurement sequencer; AFC_MEAS_AVG_EN enables two-round averaging
module afc_cntr_seq #(
  parameter int CNT_W    = 14,
  parameter int STB_BASE = 8
) (
  input logic           clk,
  input logic           rst,
  afc_cntr_seq_if.slave bus
);
  // Duration counter must hold STB_BASE<<3 - 1 and the 7-bit count field
  localparam int DUR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_STABLE, S_CRST, S_COUNT, S_SYNC, S_CAPT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [6:0]       n_q, n_d;
  logic [CNT_W-1:0] ndec_q, ndec_d;
  logic [CNT_W-1:0] meas_err_q, meas_err_d;
  logic             meas_hi_q, meas_hi_d;
  logic [DUR_W-1:0] stable_m1;
  logic [CNT_W-1:0] meas_val;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   diff_abs;
`ifdef AFC_MEAS_AVG_EN
  logic             round_q, round_d;
  logic [CNT_W-1:0] ncntr1_q, ncntr1_d;
  logic [CNT_W:0]   sum;
`endif

  // Settle length minus one, loaded straight into the duration counter at acceptance
  assign stable_m1 = DUR_W'((STB_BASE << bus.rg_afc_vcostable_time) - 1);

  // Measured count and its signed distance from the expected count
  always_comb begin
`ifdef AFC_MEAS_AVG_EN
    sum      = {1'b0, ncntr1_q} + {1'b0, bus.a2d_afc_ncntr} + {{CNT_W{1'b0}}, 1'b1};
    meas_val = CNT_W'(sum >> 1);
`else
    meas_val = bus.a2d_afc_ncntr;
`endif
    diff     = {1'b0, meas_val} - {1'b0, ndec_q};
    diff_abs = diff[CNT_W] ? -diff : diff;
  end

  // State, duration counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dur_q      <= '0;
      n_q        <= '0;
      ndec_q     <= '0;
      meas_err_q <= '0;
      meas_hi_q  <= 1'b0;
`ifdef AFC_MEAS_AVG_EN
      round_q    <= 1'b0;
      ncntr1_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      n_q        <= n_d;
      ndec_q     <= ndec_d;
      meas_err_q <= meas_err_d;
      meas_hi_q  <= meas_hi_d;
`ifdef AFC_MEAS_AVG_EN
      round_q    <= round_d;
      ncntr1_q   <= ncntr1_d;
`endif
    end
  end

  // Next-state: timed phases count down to zero, abort overrides everything outside IDLE
  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    n_d        = n_q;
    ndec_d     = ndec_q;
    meas_err_d = meas_err_q;
    meas_hi_d  = meas_hi_q;
`ifdef AFC_MEAS_AVG_EN
    round_d    = round_q;
    ncntr1_d   = ncntr1_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.meas_req && !bus.meas_abort) begin
          state_d = S_STABLE;
          dur_d   = stable_m1;
          n_d     = bus.rg_afc_cnt_time;
          ndec_d  = bus.ndec;
        end
      end
      S_STABLE: begin
        if (dur_q != '0) begin
          dur_d = dur_q - DUR_W'(1);
        end else begin
          state_d = S_CRST;
          dur_d   = DUR_W'(1);
        end
      end
      S_CRST: begin
        if (dur_q != '0) begin
          dur_d = dur_q - DUR_W'(1);
        end else begin
          state_d = S_COUNT;
          dur_d   = DUR_W'(n_q);
        end
      end
      S_COUNT: begin
        if (dur_q != '0) begin
          dur_d = dur_q - DUR_W'(1);
        end else begin
          state_d = S_SYNC;
        end
      end
      S_SYNC: state_d = S_CAPT;
      S_CAPT: begin
`ifdef AFC_MEAS_AVG_EN
        if (!round_q) begin
          ncntr1_d = bus.a2d_afc_ncntr;
          round_d  = 1'b1;
          state_d  = S_CRST;
          dur_d    = DUR_W'(1);
        end else begin
          round_d    = 1'b0;
          state_d    = S_DONE;
          meas_err_d = CNT_W'(diff_abs);
          meas_hi_d  = ~diff[CNT_W] & (|diff);
        end
`else
        state_d    = S_DONE;
        meas_err_d = CNT_W'(diff_abs);
        meas_hi_d  = ~diff[CNT_W] & (|diff);
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.meas_abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      dur_d      = '0;
      meas_err_d = meas_err_q;
      meas_hi_d  = meas_hi_q;
`ifdef AFC_MEAS_AVG_EN
      round_d    = 1'b0;
`endif
    end
  end

  // Counter controls and status decoded from the current state
  always_comb begin
    bus.afc_cntr_rstn    = 1'b1;
    bus.afc_cntr_en      = 1'b0;
    bus.afc_cntr_datasyn = 1'b0;
    bus.meas_busy        = 1'b1;
    bus.meas_done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.afc_cntr_rstn = 1'b0;
        bus.meas_busy     = 1'b0;
      end
      S_STABLE, S_CRST: bus.afc_cntr_rstn    = 1'b0;
      S_COUNT:          bus.afc_cntr_en      = 1'b1;
      S_SYNC:           bus.afc_cntr_datasyn = 1'b1;
      S_DONE:           bus.meas_done        = 1'b1;
      default: ;
    endcase
  end

  assign bus.meas_err = meas_err_q;
  assign bus.meas_hi  = meas_hi_q;
endmodule

// File: tb/tb_afc_cntr_seq.sv
// tb/tb_afc_cntr_seq.sv - self-checking bench for afc_cntr_seq against a phase-level reference model
module tb_afc_cntr_seq;
  localparam int CNT_W    = 14;
  localparam int STB_BASE = 8;
`ifdef AFC_MEAS_AVG_EN
  localparam int ROUNDS = 2;
`else
  localparam int ROUNDS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  afc_cntr_seq_if #(.CNT_W(CNT_W)) bus_if ();

  afc_cntr_seq #(.CNT_W(CNT_W), .STB_BASE(STB_BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Latency from the accepting edge to the edge that raises done
  function automatic int exp_latency(input int code, input int n);
    int s;
    s = STB_BASE << code;
    return (ROUNDS == 2) ? s + 2 * n + 10 : s + n + 5;
  endfunction

  function automatic int model_meas(input int nc1, input int nc2);
    return (ROUNDS == 2) ? (nc1 + nc2 + 1) / 2 : nc1;
  endfunction

  // Present a request; returns at the negedge after the accepting edge with inputs scrambled
  task automatic start_req(input int code, input int n, input int ndec);
    @(negedge clk);
    bus_if.rg_afc_vcostable_time = 2'(code);
    bus_if.rg_afc_cnt_time       = 7'(n);
    bus_if.ndec                  = CNT_W'(ndec);
    bus_if.meas_req              = 1'b1;
    @(negedge clk);
    bus_if.meas_req              = 1'b0;
    bus_if.rg_afc_vcostable_time = 2'($urandom);
    bus_if.rg_afc_cnt_time       = 7'($urandom);
    bus_if.ndec                  = CNT_W'($urandom);
  endtask

  task automatic run_meas(input string tag, input int code, input int n, input int ndec,
                          input int nc1, input int nc2, input bit req_in_stable);
    int lat, mval, d, done_edge, done_cnt, en_cnt, syn_cnt, rstn_cnt;
    bit prev_syn, busy_ok;
    lat = exp_latency(code, n);
    mval = model_meas(nc1, nc2);
    d = mval - ndec;
    done_edge = -1; done_cnt = 0; en_cnt = 0; syn_cnt = 0; rstn_cnt = 0;
    prev_syn = 1'b0; busy_ok = 1'b1;
    bus_if.a2d_afc_ncntr = CNT_W'($urandom);
    start_req(code, n, ndec);
    for (int k = 1; k <= lat + 8; k++) begin
      @(negedge clk);
      if (bus_if.meas_done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
      if (bus_if.afc_cntr_en) en_cnt++;
      if (bus_if.afc_cntr_rstn) rstn_cnt++;
      if (k <= lat && !bus_if.meas_busy) busy_ok = 1'b0;
      if (bus_if.afc_cntr_datasyn) begin
        syn_cnt++;
        bus_if.a2d_afc_ncntr = CNT_W'((syn_cnt == 1) ? nc1 : nc2);
      end else if (!prev_syn) begin
        bus_if.a2d_afc_ncntr = CNT_W'($urandom);
      end
      prev_syn = bus_if.afc_cntr_datasyn;
      bus_if.meas_req = req_in_stable && (k == 2);
    end
    check({tag, ".latency"}, done_edge, lat);
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".en_cycles"}, en_cnt, ROUNDS * (n + 1));
    check({tag, ".rstn_cycles"}, rstn_cnt, ROUNDS * (n + 3) + 1);
    check({tag, ".datasyn_cnt"}, syn_cnt, ROUNDS);
    check({tag, ".busy_during"}, busy_ok, 1);
    check({tag, ".busy_after"}, bus_if.meas_busy, 0);
    check({tag, ".err"}, bus_if.meas_err, (d < 0) ? -d : d);
    check({tag, ".hi"}, bus_if.meas_hi, (d > 0) ? 1 : 0);
  endtask

  initial begin
    int done_seen;
    bit got;
    bus_if.meas_req = 1'b0;
    bus_if.meas_abort = 1'b0;
    bus_if.rg_afc_vcostable_time = '0;
    bus_if.rg_afc_cnt_time = '0;
    bus_if.ndec = '0;
    bus_if.a2d_afc_ncntr = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.rstn", bus_if.afc_cntr_rstn, 0);
    check("rst.en", bus_if.afc_cntr_en, 0);
    check("rst.datasyn", bus_if.afc_cntr_datasyn, 0);
    check("rst.busy", bus_if.meas_busy, 0);
    check("rst.done", bus_if.meas_done, 0);
    check("rst.err", bus_if.meas_err, 0);
    check("rst.hi", bus_if.meas_hi, 0);
    rst = 1'b0;

    // directed vectors and boundaries
    run_meas("v2", 3, 63, 'h200, 'h1F0, 'h1F0, 1'b0);
    run_meas("eq", 1, 5, 'h3FFF, 'h3FFF, 'h3FFF, 1'b0);
    run_meas("max", 2, 0, 0, 'h3FFF, 'h3FFF, 1'b0);
    run_meas("n127", 0, 127, 'h1234, 'h0AB0, 'h0AB1, 1'b1);
    run_meas("avg", 0, 18, 'h100, 'h100, 'h103, 1'b0);

    // randomized measurements
    for (int r = 0; r < 5; r++) begin
      run_meas($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
               int'($urandom_range(0, 16383)), 1'($urandom));
    end

    // v1 leaves err=5 hi=1 for the abort checks that follow
    run_meas("v1", 0, 18, 'h100, 'h105, 'h105, 1'b0);

    // abort in COUNT
    start_req(0, 18, 'h100);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus_if.afc_cntr_en;
    end
    check("abort.reach_count", got, 1);
    @(negedge clk);
    bus_if.meas_abort = 1'b1;
    @(negedge clk);
    bus_if.meas_abort = 1'b0;
    check("abort.busy", bus_if.meas_busy, 0);
    check("abort.rstn", bus_if.afc_cntr_rstn, 0);
    check("abort.en", bus_if.afc_cntr_en, 0);
    done_seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus_if.meas_done || bus_if.meas_busy) done_seen++;
    end
    check("abort.no_done", done_seen, 0);
    check("abort.err_held", bus_if.meas_err, 5);
    check("abort.hi_held", bus_if.meas_hi, 1);

    // abort together with request in IDLE drops the request
    bus_if.meas_abort = 1'b1;
    bus_if.meas_req = 1'b1;
    @(negedge clk);
    bus_if.meas_abort = 1'b0;
    bus_if.meas_req = 1'b0;
    check("abort_req.busy", bus_if.meas_busy, 0);
    done_seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_if.meas_done) done_seen++;
    end
    check("abort_req.no_done", done_seen, 0);
    check("abort_idle.err_held", bus_if.meas_err, 5);

    // reset in SYNC
    start_req(0, 4, 'h10);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus_if.afc_cntr_datasyn;
    end
    check("rst_sync.reach_sync", got, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_sync.rstn", bus_if.afc_cntr_rstn, 0);
    check("rst_sync.datasyn", bus_if.afc_cntr_datasyn, 0);
    check("rst_sync.busy", bus_if.meas_busy, 0);
    check("rst_sync.err", bus_if.meas_err, 0);
    check("rst_sync.hi", bus_if.meas_hi, 0);
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_if.meas_done) done_seen++;
    end
    check("rst_sync.no_done", done_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
